dsp_mac_array: RTL

- Parametrised N-channel multiply-accumulate engine for the DSP datapath; each channel multiplies its sample by a per-channel coefficient and integrates over a programmable frame length.
- Adds valid/ready flow control on input and output, selectable saturation, per-frame overflow flags and a frame counter.
- Sits between the sample front-end and the result/post-processing stage.

---
 rtl/dsp_mac_array_if.sv | 42 ++++
 rtl/dsp_mac_array.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dsp_mac_array_if.sv
// Bus bundle for dsp_mac_array: sample input stream, coefficient load,
// frame control and the frame-result output stream.
//
// Handshake rule, both streams: a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds valid and its
// payload stable until that transfer. The consumer may raise or lower
// ready freely.
interface dsp_mac_array_if #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int CW  = 16,
    parameter int LW  = 8
) ();
    localparam int OW = DW + CW;

    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*DW-1:0]    in_data;
    logic                 coef_load;
    logic [NCH*CW-1:0]    coef_in;
    logic [LW-1:0]        acc_len;
    logic                 sat_en;
    logic                 clear;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*OW-1:0]    out_data;
    logic [NCH-1:0]       out_ovf;
    logic                 ovf_sticky;
    logic [7:0]           frame_count;

    // Engine side
    modport slave (
        input  in_valid, in_data, coef_load, coef_in, acc_len, sat_en, clear, out_ready,
        output in_ready, out_valid, out_data, out_ovf, ovf_sticky, frame_count
    );

    // Front-end / post-processing side
    modport master (
        output in_valid, in_data, coef_load, coef_in, acc_len, sat_en, clear, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, ovf_sticky, frame_count
    );
endinterface

// File: rtl/dsp_mac_array.sv
// N-channel multiply-accumulate engine. Three stages: sample register (S1),
// product register (S2), accumulate / frame-end (S3) feeding a held output
// register. One global advance signal stalls every stage, bubbles included,
// while a result waits for downstream.
module dsp_mac_array #(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int GUARD = 8,
    parameter int LW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dsp_mac_array_if.slave   bus
);
    localparam int OW = DW + CW;
    localparam int AW = OW + GUARD;

    logic                      s1_valid_q;
    logic [NCH*DW-1:0]         s1_data_q;
    logic [NCH*CW-1:0]         coef_q;
    logic                      s2_valid_q;
    logic [NCH-1:0][OW-1:0]    prod_q;
    logic [NCH-1:0][AW-1:0]    acc_q;
    logic [LW-1:0]             cnt_q;
    logic [LW-1:0]             len_q;
    logic                      out_valid_q;
    logic [NCH-1:0][OW-1:0]    out_data_q;
    logic [NCH-1:0]            out_ovf_q;
    logic                      ovf_sticky_q;
    logic [7:0]                frame_count_q;

    logic                      adv;
    logic                      accept;
    logic                      s3_fire;
    logic                      frame_end;
    logic [LW-1:0]             len_d;
    logic [NCH-1:0][OW-1:0]    prod_d;
    logic [NCH-1:0][AW-1:0]    sum_d;
    logic [NCH-1:0][OW-1:0]    conv_d;
    logic [NCH-1:0]            ovf_d;

    // Stall everything only while a presented result is being refused.
    assign adv       = !(out_valid_q && !bus.out_ready);
    assign accept    = bus.in_valid && adv;
    assign s3_fire   = adv && s2_valid_q;
    // At frame start the live acc_len applies (0 means 1); mid-frame the latched length.
    assign len_d     = (cnt_q != '0) ? len_q : ((bus.acc_len == '0) ? LW'(1) : bus.acc_len);
    assign frame_end = s3_fire && (cnt_q == len_d - LW'(1));

    // Per-channel product, running sum, range check and output conversion.
    always_comb begin
        prod_d = '0;
        sum_d  = '0;
        conv_d = '0;
        ovf_d  = '0;
        for (int k = 0; k < NCH; k++) begin
            prod_d[k] = $signed({{CW{s1_data_q[k*DW+DW-1]}}, s1_data_q[k*DW +: DW]}) *
                        $signed({{DW{coef_q[k*CW+CW-1]}}, coef_q[k*CW +: CW]});
            sum_d[k]  = acc_q[k] + {{GUARD{prod_q[k][OW-1]}}, prod_q[k]};
            // In range only if the bits above the OW-bit sign all copy it.
            ovf_d[k]  = !((&sum_d[k][AW-1:OW-1]) || !(|sum_d[k][AW-1:OW-1]));
            conv_d[k] = sum_d[k][OW-1:0];
            if (ovf_d[k] && bus.sat_en) begin
                conv_d[k] = sum_d[k][AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            end
        end
    end

    // Coefficients follow coef_load independently of stalls; clear keeps them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q <= '0;
        end else if (bus.coef_load) begin
            coef_q <= bus.coef_in;
        end
    end

    // S1 sample capture and S2 product register, both frozen on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
        end else if (bus.clear) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_data_q <= bus.in_data;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                prod_q <= prod_d;
            end
        end
    end

    // S3 accumulators and sample counter; frame end restarts both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= LW'(1);
        end else if (bus.clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (s3_fire) begin
            if (cnt_q == '0) begin
                len_q <= len_d;
            end
            if (frame_end) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum_d;
                cnt_q <= cnt_q + LW'(1);
            end
        end
    end

    // Result register, downstream handshake, frame counter and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_ovf_q     <= '0;
            ovf_sticky_q  <= 1'b0;
            frame_count_q <= '0;
        end else if (bus.clear) begin
            out_valid_q   <= 1'b0;
            out_ovf_q     <= '0;
            ovf_sticky_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                frame_count_q <= frame_count_q + 8'd1;
                ovf_sticky_q  <= ovf_sticky_q | (|out_ovf_q);
            end
            // frame_end implies adv, so a held result is never overwritten.
            if (frame_end) begin
                out_valid_q <= 1'b1;
                out_data_q  <= conv_d;
                out_ovf_q   <= ovf_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = adv;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.ovf_sticky  = ovf_sticky_q;
    assign bus.frame_count = frame_count_q;
endmodule
